// File: rtl/compact_ga_controller.sv
// compact_ga_controller
//   Sequencer for a compact-GA probability-vector population. Each generation
//   it samples two individuals from the population, sends each to an external
//   fitness evaluator, picks the winner and issues one population update.
//   It tracks the generation count and the best individual so far. A run stops
//   when the target fitness is reached or the generation limit is hit.
//
// Ports
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   start, abort              run control; abort wins over start and everything else
//   max_gens, target_fit,
//   tax_in                    run settings, latched when a run starts (max_gens 0 = unbounded)
//   pop_ce, pop_we            population sample / update strobes (never high together)
//   pop_winner, pop_tax       update payload; pop_tax is the latched tax
//   pop_individual            population sample, valid the cycle after pop_ce
//   eval_valid/eval_ready,
//   eval_data                 evaluation request channel
//   fit_valid, fit_value      evaluation result strobe
//   busy, done                run status (done is a level)
//   best_individual,
//   best_fitness, gen_count   run results
//   state_dbg                 current FSM state encoding
//
// Handshake: eval_valid rises with eval_data already stable, and both hold until
// the cycle in which eval_ready is also high; that cycle is the transfer. A
// fit_valid in the transfer cycle itself is not taken; the first result accepted
// is one cycle later, and results arriving at any other time are ignored.

module compact_ga_controller #(
   parameter int Width    = 32,
   parameter int FitWidth = 16,
   parameter int TaxWidth = 4,
   parameter int GenWidth = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [GenWidth-1:0] max_gens,
   input  logic [FitWidth-1:0] target_fit,
   input  logic [TaxWidth-1:0] tax_in,
   output logic                pop_ce,
   output logic                pop_we,
   output logic [Width-1:0]    pop_winner,
   output logic [TaxWidth-1:0] pop_tax,
   input  logic [Width-1:0]    pop_individual,
   output logic                eval_valid,
   input  logic                eval_ready,
   output logic [Width-1:0]    eval_data,
   input  logic                fit_valid,
   input  logic [FitWidth-1:0] fit_value,
   output logic                busy,
   output logic                done,
   output logic [Width-1:0]    best_individual,
   output logic [FitWidth-1:0] best_fitness,
   output logic [GenWidth-1:0] gen_count,
   output logic [3:0]          state_dbg
);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_GEN_A = 4'd1,
      S_CAP_A = 4'd2,
      S_REQ_A = 4'd3,
      S_RES_A = 4'd4,
      S_GEN_B = 4'd5,
      S_CAP_B = 4'd6,
      S_REQ_B = 4'd7,
      S_RES_B = 4'd8,
      S_CMP   = 4'd9,
      S_UPD   = 4'd10,
      S_DONE  = 4'd11
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [Width-1:0]    ind_a;
   logic [Width-1:0]    ind_b;
   logic [FitWidth-1:0] fit_a;
   logic [FitWidth-1:0] fit_b;
   logic [FitWidth-1:0] target_q;
   logic [GenWidth-1:0] max_q;
   logic [GenWidth-1:0] gen_inc;
   logic [Width-1:0]    win_ind;
   logic [FitWidth-1:0] win_fit;
   logic                a_wins;
   logic                stop_run;
   logic                launch;

   assign state_dbg = state;

   // Ties go to A.
   assign a_wins  = (fit_a >= fit_b);
   assign win_ind = a_wins ? ind_a : ind_b;
   assign win_fit = a_wins ? fit_a : fit_b;

   // Saturating increment; the stop test looks at the post-update count.
   assign gen_inc  = (gen_count == {GenWidth{1'b1}}) ? gen_count : gen_count + GenWidth'(1);
   // best_fitness already includes this generation's winner when in UPD.
   assign stop_run = (best_fitness >= target_q) ||
                     ((max_q != '0) && (gen_inc == max_q));

   assign launch = start && !abort;

   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (start) state_nxt = S_GEN_A;
            S_GEN_A: state_nxt = S_CAP_A;
            S_CAP_A: state_nxt = S_REQ_A;
            S_REQ_A: if (eval_ready) state_nxt = S_RES_A;
            S_RES_A: if (fit_valid) state_nxt = S_GEN_B;
            S_GEN_B: state_nxt = S_CAP_B;
            S_CAP_B: state_nxt = S_REQ_B;
            S_REQ_B: if (eval_ready) state_nxt = S_RES_B;
            S_RES_B: if (fit_valid) state_nxt = S_CMP;
            S_CMP:   state_nxt = S_UPD;
            S_UPD:   state_nxt = stop_run ? S_DONE : S_GEN_A;
            S_DONE:  if (start) state_nxt = S_GEN_A;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // Strobes and status are registered from the next state so they line up
   // exactly with the state they belong to.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= S_IDLE;
         pop_ce          <= 1'b0;
         pop_we          <= 1'b0;
         pop_winner      <= '0;
         pop_tax         <= '0;
         eval_valid      <= 1'b0;
         eval_data       <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         best_individual <= '0;
         best_fitness    <= '0;
         gen_count       <= '0;
         ind_a           <= '0;
         ind_b           <= '0;
         fit_a           <= '0;
         fit_b           <= '0;
         target_q        <= '0;
         max_q           <= '0;
      end else begin
         state      <= state_nxt;
         pop_ce     <= (state_nxt == S_GEN_A) || (state_nxt == S_GEN_B);
         pop_we     <= (state_nxt == S_UPD);
         eval_valid <= (state_nxt == S_REQ_A) || (state_nxt == S_REQ_B);
         busy       <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
         done       <= (state_nxt == S_DONE);

         if (launch && ((state == S_IDLE) || (state == S_DONE))) begin
            max_q           <= max_gens;
            target_q        <= target_fit;
            pop_tax         <= tax_in;
            gen_count       <= '0;
            best_individual <= '0;
            best_fitness    <= '0;
         end

         // Capture the sample and present it on the request bus on the same
         // edge, so eval_data is stable for the whole request phase.
         if ((state == S_CAP_A) && (state_nxt == S_REQ_A)) begin
            ind_a     <= pop_individual;
            eval_data <= pop_individual;
         end
         if ((state == S_CAP_B) && (state_nxt == S_REQ_B)) begin
            ind_b     <= pop_individual;
            eval_data <= pop_individual;
         end

         if ((state == S_RES_A) && (state_nxt == S_GEN_B)) fit_a <= fit_value;
         if ((state == S_RES_B) && (state_nxt == S_CMP))   fit_b <= fit_value;

         if ((state == S_CMP) && (state_nxt == S_UPD)) begin
            // The first generation of a run always seeds best_*.
            if ((win_fit > best_fitness) || (gen_count == '0)) begin
               best_individual <= win_ind;
               best_fitness    <= win_fit;
            end
            pop_winner <= win_ind;
         end

         if (state == S_UPD) gen_count <= gen_inc;
      end
   end

endmodule
